// File: rtl/pipe_latch_chain_if.sv
// Fetch-side handshake into the latch chain: fetch offers instr/pc_inc with in_valid,
// the chain answers with a combinational in_ready.
interface pipe_latch_chain_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc_inc;
  logic             in_ready;

  modport master (output in_valid, output in_instr, output in_pc_inc, input in_ready);
  modport slave  (input in_valid, input in_instr, input in_pc_inc, output in_ready);
endinterface

// File: rtl/pipe_latch_chain.sv
// Inter-stage pipeline latch chain with stall/flush/bubble control and retire/bubble/cycle counters.
// Latency: one edge per latch; a stall holds its latch and everything upstream, in_ready drops combinationally.
module pipe_latch_chain #(
  parameter int               STAGES = 4,
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] NOP    = 16'h0800,
  parameter int               CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  pipe_latch_chain_if.slave         fetch,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES-1:0]         stage_valid,
  output logic [STAGES*WIDTH-1:0]   stage_instr,
  output logic [STAGES*WIDTH-1:0]   stage_pc_inc,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          cycle_cnt
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc_inc;
  } latch_t;

  localparam latch_t           BUBBLE = {1'b0, NOP, {WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  latch_t            stg [STAGES];
  latch_t            nxt [STAGES];
  logic [STAGES-1:0] hold;
  logic [CNT_W-1:0]  bubble_add;
  logic              retire_now;

  // A stalled latch freezes itself and every latch upstream of it.
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      for (int j = k; j < STAGES; j++) begin
        if (stall[j]) hold[k] = 1'b1;
      end
    end
  end

  assign fetch.in_ready = ~hold[0];

  always_comb begin
    bubble_add = '0;
    if (flush[0])            nxt[0] = BUBBLE;
    else if (hold[0])        nxt[0] = stg[0];
    else if (fetch.in_valid) nxt[0] = {1'b1, fetch.in_instr, fetch.in_pc_inc};
    else                     nxt[0] = BUBBLE;
    for (int k = 1; k < STAGES; k++) begin
      if (flush[k])          nxt[k] = BUBBLE;
      else if (hold[k])      nxt[k] = stg[k];
      else if (hold[k-1]) begin
        // Hold boundary: downstream keeps moving, so it receives a bubble.
        nxt[k]     = BUBBLE;
        bubble_add = bubble_add + ONE;
      end
      else                   nxt[k] = stg[k-1];
    end
  end

  assign retire_now = stg[STAGES-1].valid & ~hold[STAGES-1] & ~flush[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stg[k] <= BUBBLE;
      retire_cnt <= '0;
      bubble_cnt <= '0;
      cycle_cnt  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) stg[k] <= nxt[k];
      cycle_cnt  <= cycle_cnt + ONE;
      bubble_cnt <= bubble_cnt + bubble_add;
      if (retire_now) retire_cnt <= retire_cnt + ONE;
    end
  end

  always_comb begin
    stage_valid  = '0;
    stage_instr  = '0;
    stage_pc_inc = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_valid[k]                = stg[k].valid;
      stage_instr[k*WIDTH +: WIDTH]  = stg[k].instr;
      stage_pc_inc[k*WIDTH +: WIDTH] = stg[k].pc_inc;
    end
  end

endmodule

// File: doc/pipe_latch_chain.md
Name: pipe_latch_chain

Overview:
- Parametrised chain of inter-stage pipeline latches (default 4: IF/ID, ID/EX, EX/MEM, MEM/WB) carrying instruction word, incremented PC and a valid bit.
- Adds per-stage stall with automatic upstream hold, per-stage flush, bubble insertion, and retire/bubble/cycle counters.
- Replaces hand-instantiated per-stage registers in the 16-bit pipelined processor; stage outputs feed decode/execute logic and the pipeline benches.

Parameters:
STAGES, 4, number of latches in the chain (>=2)
WIDTH, 16, instruction and PC width
NOP, 16'h0800, instruction word loaded into any invalid (bubble/flushed/reset) latch
CNT_W, 32, counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents an instruction
in_instr  in  WIDTH  fetched instruction
in_pc_inc  in  WIDTH  fetched PC+2
in_ready  out  1  chain accepts in_* this cycle
stall  in  STAGES  stall[k]: latch k must hold this cycle
flush  in  STAGES  flush[k]: latch k invalidated at next edge
stage_valid  out  STAGES  valid bit of latch k
stage_instr  out  STAGES*WIDTH  latch k instr in bits [k*WIDTH +: WIDTH]
stage_pc_inc  out  STAGES*WIDTH  latch k PC+2, same packing
retire_cnt  out  CNT_W  valid instructions leaving the last latch
bubble_cnt  out  CNT_W  bubbles inserted by hold boundaries
cycle_cnt  out  CNT_W  clock edges since reset

Behaviour:
- Reset (async, immediate, including mid-operation): all stage_valid=0, stage_instr=NOP, stage_pc_inc=0, all counters 0. First edge after deassertion operates normally.
- Effective hold: hold[k] = OR of stall[j] for j>=k (a stalled latch freezes every older-upstream latch). in_ready = ~hold[0], combinational.
- Per-edge update of latch k, priority order:
  1. flush[k]=1: valid<=0, instr<=NOP, pc_inc<=0. Wins over hold.
  2. hold[k]=1: keep contents.
  3. k=0, not held: load in_valid/in_instr/in_pc_inc. If in_valid=0, load a bubble (valid 0, NOP, pc_inc 0).
  4. k>0, not held, hold[k-1]=1: load a bubble; bubble_cnt+1 per such latch per edge.
  5. Otherwise: copy latch k-1.
- Latency: instruction accepted at edge t is in latch 0 after edge t and in latch k after edge t+k, absent holds/flushes.
- Retire: at an edge where stage_valid[STAGES-1]=1, hold[STAGES-1]=0 and flush[STAGES-1]=0, retire_cnt+1.
- Flushing a latch already holding a bubble changes nothing and counts nothing.
- cycle_cnt increments on every edge while rst=0.
- Counters wrap modulo 2^CNT_W, no saturation.
- Simultaneous stall[k] and flush[k]: latch k becomes a bubble and stays one while stalled; upstream latches still hold.
- Outputs are registered except in_ready.

Test Plan:
- Reset, then feed c000,c101,c202,c303,c404 with pc_inc 2,4,6,8,a on consecutive edges -> after edge 4: stage_instr = {c000,c101,c202,c303} at stages {3,2,1,0}, valid=4'b1111, retire_cnt=0. After edge 5: retire_cnt=1.
- Steady stream, stall[2]=1 for one cycle -> latches 0-2 hold, in_ready=0, latch 3 loads NOP with valid 0, bubble_cnt=1. Stream resumes with no instruction lost or duplicated.
- Full pipe with flush[1:0]=2'b11 on one edge -> latches 0,1 = NOP/valid 0/pc_inc 0, latches 2,3 advance normally. retire_cnt counts only unflushed instructions.
- stall[1] and flush[1] asserted together for 2 cycles -> latch 1 is a bubble both cycles, latch 0 held, latch 2 receives bubbles, bubble_cnt +2.
- rst pulsed between edges mid-stream -> outputs clear immediately without a clock edge. cycle_cnt=0, valid=0.
- Preload retire_cnt near 2^CNT_W-1 (force) and retire 2 instructions -> counter wraps to 1.
